instr_mem_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 32 +++
 rtl/instr_mem_loader_if.sv | 30 +++
 rtl/loader_byte_packer.sv | 36 +++
 rtl/instr_mem_loader.sv | 130 +++++++++++++
 tb/tb_instr_mem_loader.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// The byte stream is little-endian: byte 0 of each word lands in bits 7:0.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LEN_LO = 3'd2,
    LEN_HI = 3'd3,
    BYTE   = 3'd4,
    WRITE  = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } state_t;

  localparam int LEN_WIDTH      = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = 8;
  localparam bit BYTE0_IS_LSB   = 1'b1;

  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
    logic [31:0] r;
    logic [1:0]  idx;
    r   = word;
    idx = BYTE0_IS_LSB ? lane : (2'(BYTES_PER_WORD - 1) - lane);
    r[int'(idx)*LANE_W +: LANE_W] = b;
    return r;
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Host byte stream plus core instruction-memory load signals of the loader.
// slave = loader side, master = host/core side.
interface instr_mem_loader_if #(
  parameter int PC_SIZE = 10
);
  logic                start;
  logic [7:0]          byte_in;
  logic                byte_valid;
  logic                byte_ready;
  logic                rw;
  logic [31:0]         instruction_in;
  logic [PC_SIZE-1:0]  PC_write;
  logic                reset_IF_memory;
  logic                core_reset;
  logic                busy;
  logic                done;
  logic                error;

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, rw, instruction_in, PC_write,
           reset_IF_memory, core_reset, busy, done, error
  );

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, rw, instruction_in, PC_write,
           reset_IF_memory, core_reset, busy, done, error
  );
endinterface

// File: rtl/loader_byte_packer.sv
// Four-lane byte assembler: places each accepted byte in lane r_cnt and
// strobes o_word_ready together with the fourth byte of a word.
module loader_byte_packer
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_load,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_ready
);

  logic [31:0] r_lanes;
  logic [1:0]  r_cnt;
  logic [31:0] w_word;

  // o_word already contains the byte being accepted this cycle
  assign w_word       = place_byte(r_lanes, r_cnt, i_byte);
  assign o_word       = w_word;
  assign o_word_ready = i_load && (r_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lanes <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_cnt   <= '0;
    end else if (i_load) begin
      r_lanes <= w_word;
      r_cnt   <= r_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Program-load controller: takes a length-prefixed byte stream from the host,
// writes 32-bit words into the core's instruction memory, then releases the core.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int PC_SIZE   = 10,
  parameter int ADDR_STEP = 4,
  parameter int MAX_WORDS = (2**PC_SIZE) / ADDR_STEP,
  parameter int TIMEOUT   = 1_000_000
) (
  input  logic               clock,
  input  logic               reset,
  instr_mem_loader_if.slave  bus
);

  localparam int          IDLE_W      = $clog2(TIMEOUT + 1);
  localparam int          WCNT_W      = PC_SIZE + 1;
  localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);

  state_t                 r_state, w_state_nxt;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [LEN_WIDTH-1:0]   w_len_full;
  logic [WCNT_W-1:0]      r_word_cnt;
  logic [IDLE_W-1:0]      r_idle;
  logic [31:0]            r_instr;
  logic [PC_SIZE-1:0]     r_pc;

  logic                   w_byte_ready, w_rw, w_busy, w_done, w_err;
  logic                   w_core_reset, w_clr_mem, w_idle_run;
  logic                   w_accept, w_len_bad, w_timeout, w_last_word;
  logic                   w_word_ready;
  logic [31:0]            w_word;

  assign w_accept    = bus.byte_valid && w_byte_ready;
  assign w_len_full  = {bus.byte_in, r_len[7:0]};
  assign w_len_bad   = (w_len_full == '0) || (32'(w_len_full) > MAX_WORDS_U);
  assign w_timeout   = w_idle_run && !w_accept && (r_idle == IDLE_W'(TIMEOUT - 1));
  assign w_last_word = (LEN_WIDTH'(r_word_cnt) + LEN_WIDTH'(1)) == r_len;

  loader_byte_packer u_packer (
    .clock        (clock),
    .reset        (reset),
    .i_clr        (r_state != BYTE),
    .i_load       ((r_state == BYTE) && w_accept),
    .i_byte       (bus.byte_in),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_byte_ready = 1'b0;
    w_rw         = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_err        = 1'b0;
    w_core_reset = 1'b1;
    w_clr_mem    = 1'b0;
    w_idle_run   = 1'b0;
    case (r_state)
      IDLE, DONE, ERROR: begin
        w_done = (r_state == DONE);
        w_err  = (r_state == ERROR);
        w_core_reset = (r_state != DONE);
        if (bus.start) w_state_nxt = CLEAR;
      end
      CLEAR: begin
        w_rw = 1'b1; w_busy = 1'b1; w_clr_mem = 1'b1;
        w_state_nxt = LEN_LO;
      end
      LEN_LO, LEN_HI, BYTE: begin
        w_rw = 1'b1; w_busy = 1'b1; w_byte_ready = 1'b1; w_idle_run = 1'b1;
        if (w_timeout)
          w_state_nxt = ERROR;
        else if (r_state == LEN_LO && w_accept)
          w_state_nxt = LEN_HI;
        else if (r_state == LEN_HI && w_accept)
          w_state_nxt = w_len_bad ? ERROR : BYTE;
        else if (r_state == BYTE && w_word_ready)
          w_state_nxt = WRITE;
      end
      WRITE: begin
        // one-cycle bubble: the assembled word is presented to the core
        w_rw = 1'b1; w_busy = 1'b1;
        w_state_nxt = w_last_word ? DONE : BYTE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_len      <= '0;
      r_word_cnt <= '0;
      r_idle     <= '0;
      r_instr    <= '0;
      r_pc       <= '0;
    end else begin
      if (r_state == LEN_LO && w_accept) r_len[7:0]           <= bus.byte_in;
      if (r_state == LEN_HI && w_accept) r_len[LEN_WIDTH-1:8] <= bus.byte_in;

      if (w_state_nxt == CLEAR)  r_word_cnt <= '0;
      else if (r_state == WRITE) r_word_cnt <= r_word_cnt + WCNT_W'(1);

      if (w_idle_run && !w_accept) r_idle <= r_idle + IDLE_W'(1);
      else                         r_idle <= '0;

      if (r_state == BYTE && w_word_ready) begin
        r_instr <= w_word;
        r_pc    <= PC_SIZE'(32'(r_word_cnt) * ADDR_STEP);
      end
    end
  end

  assign bus.byte_ready      = w_byte_ready;
  assign bus.rw              = w_rw;
  assign bus.instruction_in  = r_instr;
  assign bus.PC_write        = r_pc;
  assign bus.reset_IF_memory = w_clr_mem;
  assign bus.core_reset      = w_core_reset;
  assign bus.busy            = w_busy;
  assign bus.done            = w_done;
  assign bus.error           = w_err;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected core writes are queued as
// words are issued and a negedge monitor matches them against WRITE cycles.
module tb_instr_mem_loader;

  localparam int PC_SIZE   = 10;
  localparam int ADDR_STEP = 4;
  localparam int MAX_WORDS = 256;
  localparam int TIMEOUT   = 16;

  typedef struct {
    logic [31:0]        instr;
    logic [PC_SIZE-1:0] pc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   wr_seen = 0;
  exp_t exp_q[$];
  logic [31:0] prog[$];

  always #5 clock = ~clock;

  instr_mem_loader_if #(.PC_SIZE(PC_SIZE)) bus ();

  instr_mem_loader #(
    .PC_SIZE(PC_SIZE), .ADDR_STEP(ADDR_STEP), .MAX_WORDS(MAX_WORDS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // A WRITE cycle is the only busy/rw state that is neither CLEAR nor accepting bytes
  always @(negedge clock) begin
    if (reset === 1'b0 && bus.busy && bus.rw && !bus.byte_ready && !bus.reset_IF_memory) begin
      exp_t e;
      checks++;
      wr_seen++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: actual instr=%h pc=%h required no write",
                 bus.instruction_in, bus.PC_write);
      end else begin
        e = exp_q.pop_front();
        if (bus.instruction_in !== e.instr || bus.PC_write !== e.pc) begin
          errors++;
          $display("FAIL write_%0d: actual instr=%h pc=%h required instr=%h pc=%h",
                   wr_seen, bus.instruction_in, bus.PC_write, e.instr, e.pc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gap;
    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    if (gap > 0) begin
      bus.byte_valid = 1'b0;
      repeat (gap) tick();
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clock);
      if (bus.byte_ready) begin
        tick();
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL byte_accept_timeout: actual=not accepted required=accepted byte %h", b);
    bus.byte_valid = 1'b0;
  endtask

  task automatic start_load();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("clear_pulse",      32'(bus.reset_IF_memory), 32'd1);
    chk("clear_busy",       32'(bus.busy), 32'd1);
    chk("clear_rw",         32'(bus.rw), 32'd1);
    chk("clear_not_ready",  32'(bus.byte_ready), 32'd0);
    chk("clear_err_clr",    32'(bus.error), 32'd0);
    tick();
    chk("len_pulse_gone",   32'(bus.reset_IF_memory), 32'd0);
    chk("len_ready",        32'(bus.byte_ready), 32'd1);
  endtask

  // Loads prog[0..len-1]; a bad length must end in ERROR with no write
  task automatic run_load(input logic [15:0] len, input int gap_max, input bit poke);
    bit ok;
    logic [31:0] w;
    exp_t e;
    ok = (len != 16'd0) && (int'(len) <= MAX_WORDS);
    start_load();
    send_byte(len[7:0], gap_max);
    send_byte(len[15:8], gap_max);
    if (!ok) begin
      bus.byte_valid = 1'b0;
      chk("badlen_error",      32'(bus.error), 32'd1);
      chk("badlen_core_reset", 32'(bus.core_reset), 32'd1);
      chk("badlen_busy",       32'(bus.busy), 32'd0);
      chk("badlen_rw",         32'(bus.rw), 32'd0);
      return;
    end
    for (int i = 0; i < int'(len); i++) begin
      w = prog[i];
      e.instr = w;
      e.pc    = PC_SIZE'((i * ADDR_STEP) % (2**PC_SIZE));
      exp_q.push_back(e);
      for (int j = 0; j < 4; j++) begin
        if (poke && i == 1 && j == 0) bus.start = 1'b1;
        send_byte(w[j*8 +: 8], gap_max);
        bus.start = 1'b0;
      end
    end
    bus.byte_valid = 1'b0;
    tick();
    chk("done_flag",       32'(bus.done), 32'd1);
    chk("done_rw",         32'(bus.rw), 32'd0);
    chk("done_core_run",   32'(bus.core_reset), 32'd0);
    chk("done_busy",       32'(bus.busy), 32'd0);
    chk("done_not_ready",  32'(bus.byte_ready), 32'd0);
    chk("writes_drained",  32'(exp_q.size()), 32'd0);
  endtask

  task automatic fill_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    exp_t e;
    bus.start = 1'b0; bus.byte_in = 8'h00; bus.byte_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_rw",         32'(bus.rw), 32'd0);
    chk("rst_instr",      bus.instruction_in, 32'd0);
    chk("rst_pc",         32'(bus.PC_write), 32'd0);
    chk("rst_clr_mem",    32'(bus.reset_IF_memory), 32'd0);
    chk("rst_core_reset", 32'(bus.core_reset), 32'd1);
    chk("rst_ready",      32'(bus.byte_ready), 32'd0);
    chk("rst_busy_done_err", {29'd0, bus.busy, bus.done, bus.error}, 32'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    tick();

    // basic two-word program
    prog.delete();
    prog.push_back(32'h0010_0513);
    prog.push_back(32'h0020_0593);
    run_load(16'd2, 0, 1'b0);

    // illegal lengths
    run_load(16'd0, 0, 1'b0);
    run_load(16'd257, 2, 1'b0);

    // random programs with gaps and a start pulse mid-load
    for (int k = 0; k < 5; k++) begin
      int n;
      n = int'($urandom_range(8, 1));
      fill_prog(n);
      run_load(16'(n), int'($urandom_range(6, 0)), (k % 2) == 1);
    end

    // timeout after two data bytes
    start_load();
    send_byte(8'd3, 0);
    send_byte(8'd0, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    bus.byte_valid = 1'b0;
    repeat (TIMEOUT - 1) tick();
    chk("timeout_not_yet", 32'(bus.error), 32'd0);
    tick();
    chk("timeout_error",      32'(bus.error), 32'd1);
    chk("timeout_core_reset", 32'(bus.core_reset), 32'd1);
    chk("timeout_busy",       32'(bus.busy), 32'd0);
    fill_prog(1);
    run_load(16'd1, 3, 1'b0);

    // asynchronous reset in the middle of a word
    fill_prog(4);
    start_load();
    send_byte(8'd4, 0);
    send_byte(8'd0, 0);
    w = prog[0];
    e.instr = w; e.pc = '0;
    exp_q.push_back(e);
    for (int j = 0; j < 4; j++) send_byte(w[j*8 +: 8], 0);
    w = prog[1];
    send_byte(w[7:0], 0);
    send_byte(w[15:8], 0);
    bus.byte_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_busy",       32'(bus.busy), 32'd0);
    chk("arst_rw",         32'(bus.rw), 32'd0);
    chk("arst_core_reset", 32'(bus.core_reset), 32'd1);
    chk("arst_ready",      32'(bus.byte_ready), 32'd0);
    chk("arst_instr",      bus.instruction_in, 32'd0);
    chk("arst_pc",         32'(bus.PC_write), 32'd0);
    chk("arst_queue",      32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    fill_prog(3);
    run_load(16'd3, 2, 1'b0);

    // full capacity
    fill_prog(MAX_WORDS);
    run_load(16'(MAX_WORDS), 1, 1'b0);
    chk("full_last_pc", 32'(bus.PC_write), 32'h3FC);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
